// File: rtl/test_seq_pkg.sv
// Shared types and width helpers for the test-run sequencer.
package test_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FINISH
  } state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a count that must hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Width of the watchdog counter, which runs 0 .. t-1.
  function automatic int unsigned tmr_w(input int unsigned t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/lowest_set.sv
// Priority encoder: index of the lowest set bit plus an all-clear flag.
module lowest_set #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          none
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int unsigned i = W; i > 0; i--) begin
      if (vec[i-1]) begin
        idx  = IW'(i - 1);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Test-run controller: launches enabled channels sequentially or in parallel,
// watches done/pass under a per-launch watchdog and accumulates results.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned N_TESTS  = 32,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned PARALLEL = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic [N_TESTS-1:0]          enable_mask,
  output logic [N_TESTS-1:0]          start,
  input  logic [N_TESTS-1:0]          done,
  input  logic [N_TESTS-1:0]          pass,
  output logic                        busy,
  output logic                        all_done,
  output logic [N_TESTS-1:0]          fail_mask,
  output logic [N_TESTS-1:0]          timeout_mask,
  output logic [cnt_w(N_TESTS)-1:0]   pass_count,
  output logic [idx_w(N_TESTS)-1:0]   cur_idx
);

  localparam int unsigned IW = idx_w(N_TESTS);
  localparam int unsigned CW = cnt_w(N_TESTS);
  localparam int unsigned TW = tmr_w(TIMEOUT);

  state_e             state_q, state_d;
  logic [N_TESTS-1:0] remain_q, remain_d;
  logic [N_TESTS-1:0] start_q, start_d;
  logic [N_TESTS-1:0] fail_q, fail_d;
  logic [N_TESTS-1:0] to_q, to_d;
  logic [CW-1:0]      pc_q, pc_d;
  logic [IW-1:0]      cur_idx_q, cur_idx_d;
  logic [TW-1:0]      cnt_q, cnt_d;

  logic [N_TESTS-1:0] sel_vec;
  logic [IW-1:0]      sel_idx;
  logic               sel_none;
  logic [N_TESTS-1:0] cur_bit, hits, pass_hits, outstanding;
  logic [CW-1:0]      pc_add;
  logic               timed_out, resolved;

  // In IDLE the encoder checks the incoming mask for emptiness; otherwise it
  // picks the next channel from what remains.
  assign sel_vec = (state_q == IDLE) ? enable_mask : remain_q;

  lowest_set #(
    .W  (N_TESTS),
    .IW (IW)
  ) u_lowest_set (
    .vec  (sel_vec),
    .idx  (sel_idx),
    .none (sel_none)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run) state_d = sel_none ? FINISH : LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT: begin
        if (PARALLEL != 0) begin
          if (remain_d == '0) state_d = FINISH;
        end else if (resolved) begin
          state_d = (remain_d == '0) ? FINISH : LAUNCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: launch pulses, watchdog, result accumulation, remaining set.
  always_comb begin
    remain_d    = remain_q;
    start_d     = '0;
    fail_d      = fail_q;
    to_d        = to_q;
    pc_d        = pc_q;
    cur_idx_d   = cur_idx_q;
    cnt_d       = cnt_q;
    resolved    = 1'b0;
    cur_bit     = N_TESTS'(1) << cur_idx_q;
    timed_out   = (cnt_q == TW'(TIMEOUT - 1));
    hits        = done & remain_q;
    pass_hits   = hits & pass;
    outstanding = remain_q & ~hits;
    pc_add      = '0;
    for (int unsigned i = 0; i < N_TESTS; i++) begin
      pc_add = pc_add + CW'(pass_hits[i]);
    end

    unique case (state_q)
      IDLE: begin
        if (run) begin
          remain_d = enable_mask;
          fail_d   = '0;
          to_d     = '0;
          pc_d     = '0;
          cnt_d    = '0;
        end
      end
      LAUNCH: begin
        cnt_d = '0;
        if (PARALLEL != 0) begin
          start_d = remain_q;
        end else begin
          cur_idx_d = sel_idx;
          start_d   = N_TESTS'(1) << sel_idx;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (PARALLEL != 0) begin
          // Done takes priority over the watchdog in the same cycle.
          pc_d     = pc_q + pc_add;
          fail_d   = fail_q | (hits & ~pass);
          remain_d = outstanding;
          if (timed_out) begin
            fail_d   = fail_d | outstanding;
            to_d     = to_q | outstanding;
            remain_d = '0;
          end
        end else begin
          if ((done & cur_bit) != '0) begin
            resolved = 1'b1;
            if ((pass & cur_bit) != '0) pc_d   = pc_q + CW'(1);
            else                        fail_d = fail_q | cur_bit;
          end else if (timed_out) begin
            resolved = 1'b1;
            fail_d   = fail_q | cur_bit;
            to_d     = to_q | cur_bit;
          end
          if (resolved) remain_d = remain_q & ~cur_bit;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remain_q  <= '0;
      start_q   <= '0;
      fail_q    <= '0;
      to_q      <= '0;
      pc_q      <= '0;
      cur_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      remain_q  <= remain_d;
      start_q   <= start_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
      pc_q      <= pc_d;
      cur_idx_q <= cur_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    start        = start_q;
    busy         = (state_q != IDLE);
    all_done     = (state_q == FINISH);
    fail_mask    = fail_q;
    timeout_mask = to_q;
    pass_count   = pc_q;
    cur_idx      = cur_idx_q;
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench: one sequential and one parallel sequencer instance, each
// driven by a behavioural channel responder with programmable latency/result.
module tb_test_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         run_v   [2];
  logic [N-1:0] en_v    [2];
  logic [N-1:0] done_v  [2];
  logic [N-1:0] pass_v  [2];
  logic [N-1:0] start_o [2];
  logic [N-1:0] fail_o  [2];
  logic [N-1:0] to_o    [2];
  logic         busy_o  [2];
  logic         ad_o    [2];
  logic [2:0]   pc_o    [2];
  logic [1:0]   ci_o    [2];

  // Responder configuration (main) and state (monitor).
  int           lat  [2][N];
  logic         res  [2][N];
  logic         lvl  [2][N];
  logic [N-1:0] spur [2];
  int           cd   [2][N];
  logic         held [2][N];

  // Monitor records.
  int cyc;
  int lc        [2];
  int slog      [2][8];
  int start_cyc [2][N];
  int ad_cnt    [2];
  int ad_cyc    [2];
  int busy_cnt  [2];

  int n_chk;
  int n_fail;

  test_sequencer #(.N_TESTS(N), .TIMEOUT(TO), .PARALLEL(0)) u_seq (
    .clk(clk), .reset(reset), .run(run_v[0]), .enable_mask(en_v[0]),
    .start(start_o[0]), .done(done_v[0]), .pass(pass_v[0]), .busy(busy_o[0]),
    .all_done(ad_o[0]), .fail_mask(fail_o[0]), .timeout_mask(to_o[0]),
    .pass_count(pc_o[0]), .cur_idx(ci_o[0])
  );

  test_sequencer #(.N_TESTS(N), .TIMEOUT(TO), .PARALLEL(1)) u_par (
    .clk(clk), .reset(reset), .run(run_v[1]), .enable_mask(en_v[1]),
    .start(start_o[1]), .done(done_v[1]), .pass(pass_v[1]), .busy(busy_o[1]),
    .all_done(ad_o[1]), .fail_mask(fail_o[1]), .timeout_mask(to_o[1]),
    .pass_count(pc_o[1]), .cur_idx(ci_o[1])
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and channel responder, evaluated on every falling edge.
  initial begin
    cyc = 0;
    for (int m = 0; m < 2; m++) begin
      done_v[m] = '0;
      pass_v[m] = '0;
      for (int i = 0; i < N; i++) begin
        cd[m][i]   = 0;
        held[m][i] = 1'b0;
      end
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int m = 0; m < 2; m++) begin
        if (busy_o[m]) busy_cnt[m]++;
        if (ad_o[m]) begin
          ad_cnt[m]++;
          ad_cyc[m] = cyc;
        end
        for (int i = 0; i < N; i++) begin
          logic dn;
          dn = 1'b0;
          if (start_o[m][i]) begin
            if (lc[m] < 8) slog[m][lc[m]] = i;
            lc[m]++;
            start_cyc[m][i] = cyc;
          end
          if (reset) begin
            cd[m][i]   = 0;
            held[m][i] = 1'b0;
          end else if (start_o[m][i]) begin
            cd[m][i]   = lat[m][i];
            held[m][i] = 1'b0;
          end else if (held[m][i]) begin
            dn = 1'b1;
          end else if (cd[m][i] != 0) begin
            cd[m][i]--;
            if (cd[m][i] == 0) begin
              dn         = 1'b1;
              held[m][i] = lvl[m][i];
            end
          end
          done_v[m][i] = dn | spur[m][i];
          pass_v[m][i] = dn ? res[m][i] : 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ch(input int m, input int i, input int l, input logic r, input logic v);
    lat[m][i] = l;
    res[m][i] = r;
    lvl[m][i] = v;
  endtask

  // Request a run in the current cycle; r is that cycle's number.
  task automatic go(input int m, input logic [N-1:0] mask, output int r);
    lc[m]       = 0;
    ad_cnt[m]   = 0;
    ad_cyc[m]   = -1;
    busy_cnt[m] = 0;
    for (int i = 0; i < N; i++) start_cyc[m][i] = -1;
    en_v[m]  = mask;
    run_v[m] = 1'b1;
    r = cyc;
    tick();
    run_v[m] = 1'b0;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_ad(input int m, input int budget);
    int k;
    k = 0;
    while (ad_cnt[m] == 0 && k < budget) begin
      tick();
      k++;
    end
    if (ad_cnt[m] == 0) check("all_done_wait", 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  task automatic seq_default();
    for (int i = 0; i < N; i++) set_ch(0, i, 3, 1'b1, 1'b0);
    set_ch(0, 1, 3, 1'b0, 1'b0);
  endtask

  task automatic check_s1(input string p, input int r);
    check({p, "_nstart"}, lc[0], 3);
    check({p, "_order0"}, slog[0][0], 0);
    check({p, "_order1"}, slog[0][1], 1);
    check({p, "_order2"}, slog[0][2], 3);
    check({p, "_start1_cyc"}, start_cyc[0][1], r + 7);
    check({p, "_fail"}, fail_o[0], 4'b0010);
    check({p, "_tmo"}, to_o[0], 4'b0000);
    check({p, "_pc"}, pc_o[0], 2);
    check({p, "_ad_cnt"}, ad_cnt[0], 1);
    check({p, "_ad_cyc"}, ad_cyc[0], r + 16);
    check({p, "_busy"}, busy_o[0], 1'b0);
  endtask

  initial begin
    int r;
    n_chk  = 0;
    n_fail = 0;
    for (int m = 0; m < 2; m++) begin
      run_v[m] = 1'b0;
      en_v[m]  = '0;
      spur[m]  = '0;
      lc[m] = 0; ad_cnt[m] = 0; ad_cyc[m] = -1; busy_cnt[m] = 0;
      for (int i = 0; i < N; i++) set_ch(m, i, 0, 1'b1, 1'b0);
    end
    reset = 1'b1;
    repeat (3) tick();
    for (int m = 0; m < 2; m++) begin
      check("rst_busy", busy_o[m], 1'b0);
      check("rst_all_done", ad_o[m], 1'b0);
      check("rst_start", start_o[m], 4'b0000);
      check("rst_fail", fail_o[m], 4'b0000);
      check("rst_tmo", to_o[m], 4'b0000);
      check("rst_pc", pc_o[m], 0);
      check("rst_cur_idx", ci_o[m], 0);
    end
    reset = 1'b0;
    tick();

    // Sequential 1011, ch1 fails; stray done on unlaunched ch2 must be ignored.
    seq_default();
    spur[0] = 4'b0100;
    go(0, 4'b1011, r);
    step_to(r + 7);
    check("s1_cur_idx", ci_o[0], 1);
    check("s1_start1", start_o[0], 4'b0010);
    wait_ad(0, 100);
    check_s1("s1", r);
    check("s1_cur_idx_end", ci_o[0], 3);
    spur[0] = '0;

    // Channel 2 never answers.
    set_ch(0, 2, 0, 1'b1, 1'b0);
    go(0, 4'b0100, r);
    wait_ad(0, 100);
    check("tmo_tmo", to_o[0], 4'b0100);
    check("tmo_fail", fail_o[0], 4'b0100);
    check("tmo_pc", pc_o[0], 0);
    check("tmo_latency", ad_cyc[0] - start_cyc[0][2], 8);

    // Done on the very last watchdog cycle wins.
    set_ch(0, 0, 7, 1'b1, 1'b0);
    go(0, 4'b0001, r);
    wait_ad(0, 100);
    check("edge_pc", pc_o[0], 1);
    check("edge_tmo", to_o[0], 4'b0000);
    check("edge_fail", fail_o[0], 4'b0000);

    // One cycle later is too late.
    set_ch(0, 0, 8, 1'b1, 1'b0);
    go(0, 4'b0001, r);
    wait_ad(0, 100);
    check("late_pc", pc_o[0], 0);
    check("late_tmo", to_o[0], 4'b0001);
    check("late_fail", fail_o[0], 4'b0001);

    // Parallel 1111: done at +2,+2 (ch0 held as level), +5, never.
    set_ch(1, 0, 2, 1'b1, 1'b1);
    set_ch(1, 1, 2, 1'b1, 1'b0);
    set_ch(1, 2, 5, 1'b1, 1'b0);
    set_ch(1, 3, 0, 1'b1, 1'b0);
    go(1, 4'b1111, r);
    step_to(r + 2);
    check("par_start", start_o[1], 4'b1111);
    step_to(r + 5);
    check("par_pc_double", pc_o[1], 2);
    wait_ad(1, 100);
    check("par_pc", pc_o[1], 3);
    check("par_tmo", to_o[1], 4'b1000);
    check("par_fail", fail_o[1], 4'b1000);
    check("par_ad_cyc", ad_cyc[1], r + 10);
    check("par_nstart", lc[1], 4);
    check("par_cur_idx", ci_o[1], 0);

    // Parallel 0110 with ch1 failing.
    set_ch(1, 0, 0, 1'b1, 1'b0);
    set_ch(1, 1, 1, 1'b0, 1'b0);
    set_ch(1, 2, 4, 1'b1, 1'b0);
    go(1, 4'b0110, r);
    wait_ad(1, 100);
    check("par2_fail", fail_o[1], 4'b0010);
    check("par2_tmo", to_o[1], 4'b0000);
    check("par2_pc", pc_o[1], 1);
    check("par2_ad_cyc", ad_cyc[1], r + 7);

    // Empty mask clears the previous results and finishes at once.
    go(0, 4'b0000, r);
    wait_ad(0, 20);
    check("zero_ad_cyc", ad_cyc[0], r + 1);
    check("zero_busy_cycles", busy_cnt[0], 1);
    check("zero_nstart", lc[0], 0);
    check("zero_fail", fail_o[0], 4'b0000);
    check("zero_tmo", to_o[0], 4'b0000);
    check("zero_pc", pc_o[0], 0);

    // Reset in the middle of channel 3's wait.
    seq_default();
    go(0, 4'b1011, r);
    step_to(r + 13);
    check("mid_pre_fail", fail_o[0], 4'b0010);
    check("mid_pre_pc", pc_o[0], 1);
    reset = 1'b1;
    #1;
    check("mid_busy", busy_o[0], 1'b0);
    check("mid_fail", fail_o[0], 4'b0000);
    check("mid_pc", pc_o[0], 0);
    check("mid_cur_idx", ci_o[0], 0);
    check("mid_start", start_o[0], 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("mid_no_all_done", ad_cnt[0], 0);

    // Fresh run; a second request while busy must be ignored.
    go(0, 4'b1011, r);
    step_to(r + 8);
    en_v[0]  = 4'b0100;
    run_v[0] = 1'b1;
    tick();
    run_v[0] = 1'b0;
    wait_ad(0, 100);
    check_s1("rerun", r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
